// File: rtl/wght_load_pkg.sv
// wght_load_pkg: shared FSM state encoding and tag field width
// for the weight load sequencer.
package wght_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wl_state_t;

    localparam int WL_TAG_W = 4;

endpackage

// File: rtl/wght_out_fifo.sv
// wght_out_fifo: small synchronous FIFO holding returned weight words
// and their tags until the PE array accepts them.
module wght_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign w_pop = i_pop & (r_cnt != '0);

    always_ff @(posedge i_clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push)
                r_wr <= nxt(r_wr);
            if (w_pop)
                r_rd <= nxt(r_rd);
            if (i_push & ~w_pop)
                r_cnt <= r_cnt + CW'(1);
            else if (~i_push & w_pop)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

endmodule

// File: rtl/wght_load_seq.sv
// wght_load_seq: walks the weight loop nest, reads the GLB and streams
// tagged words to the PE array. WGHT_LOAD_STALL_CNT_EN adds o_stall_cnt.
module wght_load_seq
    import wght_load_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = WL_TAG_W,
    parameter int GLB_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load_start,
    input  logic [ADDR_W-1:0]    i_base_addr,
    input  logic [4:0]           i_layer_p,
    input  logic [2:0]           i_layer_q,
    input  logic [3:0]           i_layer_s,
    input  logic [2:0]           i_layer_t,
    output logic                 o_wght_glb_en,
    output logic [ADDR_W-1:0]    o_wght_glb_ra,
    input  logic [DATA_W-1:0]    i_glb_rd_data,
    output logic [DATA_W-1:0]    o_wght_data,
    output logic [2*TAG_W-1:0]   o_wght_tag,
    output logic                 o_wght_valid,
    input  logic                 i_wght_ready,
    output logic                 o_busy,
    output logic                 o_done
`ifdef WGHT_LOAD_STALL_CNT_EN
    ,
    output logic [15:0]          o_stall_cnt
`endif
);

    localparam int TW = 2*TAG_W;
    localparam int CW = $clog2(FIFO_DEPTH+1);

    wl_state_t r_state, w_nxt;

    logic [ADDR_W-1:0] r_base;
    logic [4:0] r_pb, r_p;
    logic [2:0] r_qb, r_q;
    logic [3:0] r_sb, r_s, r_row;
    logic [2:0] r_tb, r_t;

    logic [GLB_LAT-1:0]         r_pv;
    logic [GLB_LAT-1:0][TW-1:0] r_pt;

    logic w_start, w_zero, w_issue, w_last;
    logic w_last_p, w_last_s, w_last_q, w_last_r, w_last_t;
    logic [7:0]           w_inflight, w_occ;
    logic [CW-1:0]        w_fcnt;
    logic                 w_empty, w_pop;
    logic [DATA_W+TW-1:0] w_head;
    logic [ADDR_W-1:0]    w_addr;
    logic [TW-1:0]        w_tag;

    assign w_start = (r_state == ST_IDLE) & i_load_start;
    assign w_zero  = (i_layer_p == '0) | (i_layer_q == '0) |
                     (i_layer_s == '0) | (i_layer_t == '0);

    assign w_last_p = (r_p   == r_pb - 5'd1);
    assign w_last_s = (r_s   == r_sb - 4'd1);
    assign w_last_q = (r_q   == r_qb - 3'd1);
    assign w_last_r = (r_row == r_sb - 4'd1);
    assign w_last_t = (r_t   == r_tb - 3'd1);
    assign w_last   = w_last_p & w_last_s & w_last_q & w_last_r & w_last_t;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < GLB_LAT; i++)
            w_inflight = w_inflight + 8'(r_pv[i]);
    end

    // Credit: every outstanding read owns a FIFO slot on return.
    assign w_occ   = w_inflight + 8'(w_fcnt);
    assign w_issue = (r_state == ST_LOAD) && (w_occ < 8'(FIFO_DEPTH));

    // Modular sum: the low ADDR_W bits equal the full-width result's.
    assign w_addr = r_base
                  + ADDR_W'(r_p) * ADDR_W'(r_sb) * ADDR_W'(r_sb) * ADDR_W'(r_qb)
                  + ADDR_W'(r_q) * ADDR_W'(r_sb) * ADDR_W'(r_sb)
                  + ADDR_W'(r_row) * ADDR_W'(r_sb)
                  + ADDR_W'(r_s);

    assign w_tag = {TAG_W'(r_row) + TAG_W'(1), TAG_W'(r_t) + TAG_W'(1)};

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_load_start) w_nxt = w_zero ? ST_DONE : ST_LOAD;
            ST_LOAD:  if (w_issue && w_last) w_nxt = ST_DRAIN;
            ST_DRAIN: if (w_inflight == '0 && w_empty) w_nxt = ST_DONE;
            ST_DONE:  w_nxt = ST_IDLE;
            default:  w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base <= '0;
            r_pb   <= '0;
            r_qb   <= '0;
            r_sb   <= '0;
            r_tb   <= '0;
            r_p    <= '0;
            r_q    <= '0;
            r_s    <= '0;
            r_row  <= '0;
            r_t    <= '0;
        end else if (w_start) begin
            r_base <= i_base_addr;
            r_pb   <= i_layer_p;
            r_qb   <= i_layer_q;
            r_sb   <= i_layer_s;
            r_tb   <= i_layer_t;
            r_p    <= '0;
            r_q    <= '0;
            r_s    <= '0;
            r_row  <= '0;
            r_t    <= '0;
        end else if (w_issue) begin
            r_p <= w_last_p ? '0 : r_p + 5'd1;
            if (w_last_p)
                r_s <= w_last_s ? '0 : r_s + 4'd1;
            if (w_last_p & w_last_s)
                r_q <= w_last_q ? '0 : r_q + 3'd1;
            if (w_last_p & w_last_s & w_last_q)
                r_row <= w_last_r ? '0 : r_row + 4'd1;
            if (w_last_p & w_last_s & w_last_q & w_last_r)
                r_t <= w_last_t ? '0 : r_t + 3'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pv <= '0;
            r_pt <= '0;
        end else begin
            r_pv[0] <= w_issue;
            r_pt[0] <= w_tag;
            for (int i = 1; i < GLB_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pt[i] <= r_pt[i-1];
            end
        end
    end

    assign w_pop = ~w_empty & i_wght_ready;

    wght_out_fifo #(
        .W     (DATA_W + TW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_pv[GLB_LAT-1]),
        .i_data  ({r_pt[GLB_LAT-1], i_glb_rd_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_fcnt)
    );

    assign o_wght_glb_en = w_issue;
    assign o_wght_glb_ra = w_issue ? w_addr : '0;
    assign o_wght_valid  = ~w_empty;
    assign o_wght_data   = w_empty ? '0 : w_head[DATA_W-1:0];
    assign o_wght_tag    = w_empty ? '0 : w_head[DATA_W +: TW];
    assign o_busy        = (r_state == ST_LOAD) | (r_state == ST_DRAIN);
    assign o_done        = (r_state == ST_DONE);

`ifdef WGHT_LOAD_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start)
            r_stall <= '0;
        else if (~w_empty && ~i_wght_ready && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end

    assign o_stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_wght_load_seq.sv
// tb_wght_load_seq: randomized bench with a loop-nest reference model
// and a latency-accurate GLB model for wght_load_seq.
module tb_wght_load_seq;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 64;
    localparam int TAG_W      = 4;
    localparam int GLB_LAT    = 2;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               i_rst, i_start, i_ready;
    logic [ADDR_W-1:0]  i_base;
    logic [4:0]         i_p;
    logic [2:0]         i_q;
    logic [3:0]         i_s;
    logic [2:0]         i_t;
    logic               o_en;
    logic [ADDR_W-1:0]  o_ra;
    logic [DATA_W-1:0]  i_glb;
    logic [DATA_W-1:0]  o_data;
    logic [2*TAG_W-1:0] o_tag;
    logic               o_valid, o_busy, o_done;
`ifdef WGHT_LOAD_STALL_CNT_EN
    logic [15:0]        o_stall_cnt;
`endif

    always #5 clk = ~clk;

    wght_load_seq #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .GLB_LAT(GLB_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_load_start(i_start),
        .i_base_addr(i_base), .i_layer_p(i_p), .i_layer_q(i_q),
        .i_layer_s(i_s), .i_layer_t(i_t),
        .o_wght_glb_en(o_en), .o_wght_glb_ra(o_ra),
        .i_glb_rd_data(i_glb), .o_wght_data(o_data),
        .o_wght_tag(o_tag), .o_wght_valid(o_valid),
        .i_wght_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
`ifdef WGHT_LOAD_STALL_CNT_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    function automatic logic [63:0] mem_word(input logic [15:0] a);
        return {16'hA5A5, a, ~a, a ^ 16'h1234};
    endfunction

    // GLB: data for an enabled read appears GLB_LAT cycles later
    logic [15:0] g_ra [GLB_LAT];
    logic        g_v  [GLB_LAT];

    always @(posedge clk) begin
        g_v[0]  <= o_en;
        g_ra[0] <= o_ra;
        for (int i = 1; i < GLB_LAT; i++) begin
            g_v[i]  <= g_v[i-1];
            g_ra[i] <= g_ra[i-1];
        end
    end

    assign i_glb = g_v[GLB_LAT-1] ? mem_word(g_ra[GLB_LAT-1])
                                  : 64'hDEAD_BEEF_0BAD_F00D;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] e_addr [1024];
    logic [7:0]  e_tag  [1024];
    int exp_n = 0;

    task automatic build(input int p, q, s, t, input logic [15:0] base);
        exp_n = 0;
        for (int ti = 0; ti < t; ti++)
          for (int r = 0; r < s; r++)
            for (int qi = 0; qi < q; qi++)
              for (int si = 0; si < s; si++)
                for (int pi = 0; pi < p; pi++) begin
                    e_addr[exp_n] = 16'(int'(base) + pi*s*s*q + qi*s*s + r*s + si);
                    e_tag[exp_n]  = {4'(r+1), 4'(ti+1)};
                    exp_n++;
                end
    endtask

    int rd_i = 0;
    int acc_i = 0;
    int done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_d;
    logic [7:0]  prev_t;

    always @(negedge clk) begin
        if (i_rst) begin
            rd_i = 0;
            acc_i = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_data", o_data, prev_d);
                chk("hold_tag", 64'(o_tag), 64'(prev_t));
            end
            if (o_en) begin
                chk("credit", 64'((rd_i - acc_i) < FIFO_DEPTH), 64'd1);
                if (rd_i < exp_n)
                    chk("rd_addr", 64'(o_ra), 64'(e_addr[rd_i]));
                else
                    chk("rd_over", 64'(rd_i + 1), 64'(exp_n));
                rd_i++;
            end
            if (o_valid && i_ready) begin
                if (acc_i < exp_n) begin
                    chk("data", o_data, mem_word(e_addr[acc_i]));
                    chk("tag", 64'(o_tag), 64'(e_tag[acc_i]));
                end else begin
                    chk("word_over", 64'(acc_i + 1), 64'(exp_n));
                end
                acc_i++;
            end
            prev_stall = o_valid && !i_ready;
            prev_d = o_data;
            prev_t = o_tag;
            if (o_done)
                done_cnt++;
        end
    end

    task automatic chk_zero(input string pfx);
        chk({pfx, "_en"}, 64'(o_en), 64'd0);
        chk({pfx, "_ra"}, 64'(o_ra), 64'd0);
        chk({pfx, "_valid"}, 64'(o_valid), 64'd0);
        chk({pfx, "_data"}, o_data, 64'd0);
        chk({pfx, "_tag"}, 64'(o_tag), 64'd0);
        chk({pfx, "_busy"}, 64'(o_busy), 64'd0);
        chk({pfx, "_done"}, 64'(o_done), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_ready = 1'b1;
        exp_n = 0;
        @(posedge clk);
        #1;
        chk_zero("rst");
        i_rst = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for st_len
    // cycles starting st_at cycles after the first valid word
    task automatic run(input int p, q, s, t, input logic [15:0] base,
                       input int mode, st_at, st_len, abort_at);
        int e_cyc, v_first, v_last, d0, done_k;
        bit done_seen;
        do_reset();
        build(p, q, s, t, base);
        d0 = done_cnt;
        i_p = 5'(p);
        i_q = 3'(q);
        i_s = 4'(s);
        i_t = 3'(t);
        i_base = base;
        i_start = 1'b1;
        e_cyc = -1;
        v_first = -1;
        v_last = -1;
        done_k = -1;
        done_seen = 1'b0;
        for (int k = 0; k < 4000 && !done_seen; k++) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
            if (k == abort_at) begin
                i_rst = 1'b1;
                @(posedge clk);
                #1;
                chk_zero("abort");
                i_rst = 1'b0;
                return;
            end
            case (mode)
                0: i_ready = 1'b1;
                1: i_ready = ($urandom_range(0, 3) != 0);
                default: i_ready = !(v_first >= 0 && k >= v_first + st_at &&
                                     k < v_first + st_at + st_len);
            endcase
            @(negedge clk);
            if (o_en && e_cyc < 0)
                e_cyc = k;
            if (o_valid) begin
                if (v_first < 0)
                    v_first = k;
                v_last = k;
            end
            if (o_done) begin
                done_seen = 1'b1;
                done_k = k;
            end
        end
        chk("done_seen", 64'(done_seen), 64'd1);
        repeat (3) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("idle_busy", 64'(o_busy), 64'd0);
        chk("rd_total", 64'(rd_i), 64'(exp_n));
        chk("acc_total", 64'(acc_i), 64'(exp_n));
        if (exp_n == 0)
            chk("zero_done_lat", 64'(done_k + 1 <= 2), 64'd1);
        if (mode == 0 && exp_n > 0) begin
            chk("latency", 64'(v_first - e_cyc), 64'(GLB_LAT + 1));
            chk("sustain", 64'(v_last - v_first + 1), 64'(exp_n));
        end
`ifdef WGHT_LOAD_STALL_CNT_EN
        if (mode == 2)
            chk("stall_cnt", 64'(o_stall_cnt), 64'(st_len));
`endif
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_ready = 1'b1;
        i_base = '0;
        i_p = '0;
        i_q = '0;
        i_s = '0;
        i_t = '0;
        repeat (2) @(posedge clk);
        run(2, 1, 3, 1, 16'h0000, 0, 0, 0, -1);
        run(1, 1, 1, 3, 16'h0040, 0, 0, 0, -1);
        run(3, 2, 3, 1, 16'h0100, 2, 5, 10, -1);
        run(3, 2, 3, 1, 16'h0200, 2, 4, 7, -1);
        run(2, 0, 3, 1, 16'h0300, 0, 0, 0, -1);
        run(1, 1, 1, 0, 16'h0300, 0, 0, 0, -1);
        run(3, 2, 3, 2, 16'h0400, 1, 0, 0, 6);
        run(2, 2, 2, 2, 16'h0500, 1, 0, 0, -1);
        run(4, 3, 3, 2, 16'hFFF0, 0, 0, 0, -1);
        for (int n = 0; n < 4; n++)
            run($urandom_range(1, 4), $urandom_range(1, 3),
                $urandom_range(1, 3), $urandom_range(1, 3),
                16'($urandom), 1, 0, 0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
